bp_core_lce_req_arbiter: RTL and testbench

Parametrised N-channel LCE request concentrator for the core tile. It merges the request streams of `num_lce_p` cache LCEs (I$, D$, and any added accelerator caches) onto one outbound LCE request link, replacing the fixed two-port request wiring. It provides round-robin arbitration, per-channel outstanding-request credit tracking with full/empty status, and a registered output stage. It sits between the per-cache LCEs and the tile's coherence network adapter.

---
 rtl/bp_core_lce_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_bp_core_lce_req_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bp_core_lce_req_arbiter.sv
// bp_core_lce_req_arbiter
// Round-robin concentrator that merges num_lce_p LCE request streams onto one
// outbound link through a single registered output slot. Each channel has an
// outstanding-request credit counter; a full channel is not eligible. A channel
// may lock the grant across consecutive beats.
module bp_core_lce_req_arbiter #(
  parameter int num_lce_p   = 2,
  parameter int req_width_p = 128,
  parameter int credits_p   = 8,
  parameter int lock_en_p   = 1,
  localparam int cnt_width_lp = $clog2(credits_p + 1),
  localparam int id_width_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_lce_p*req_width_p-1:0] lce_req_i,
  input  logic [num_lce_p-1:0]             lce_req_v_i,
  input  logic [num_lce_p-1:0]             lce_req_lock_i,
  output logic [num_lce_p-1:0]             lce_req_ready_o,
  input  logic [num_lce_p-1:0]             credit_return_i,
  output logic [num_lce_p-1:0]             credits_full_o,
  output logic [num_lce_p-1:0]             credits_empty_o,
  output logic [req_width_p-1:0]           lce_req_o,
  output logic [id_width_lp-1:0]           lce_req_src_o,
  output logic                             lce_req_v_o,
  input  logic                             lce_req_ready_i,
  output logic                             credit_err_o
);

  // Highest channel id: last_gnt resets here so channel 0 is searched first.
  localparam logic [id_width_lp-1:0]  last_id_lp  = id_width_lp'(num_lce_p - 1);
  localparam logic [cnt_width_lp-1:0] credits_lp  = cnt_width_lp'(credits_p);
  localparam logic [cnt_width_lp-1:0] cnt_zero_lp = {cnt_width_lp{1'b0}};
  localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);

  // Output slot
  logic                    v_q, v_d;
  logic [req_width_p-1:0]  data_q, data_d;
  logic [id_width_lp-1:0]  src_q, src_d;

  // Arbitration state
  logic [id_width_lp-1:0]  last_gnt_q, last_gnt_d;
  logic                    locked_q, locked_d;

  // Credit state
  logic [cnt_width_lp-1:0] cnt_q [num_lce_p];
  logic [cnt_width_lp-1:0] cnt_d [num_lce_p];
  logic [num_lce_p-1:0]    full_q, full_d;
  logic [num_lce_p-1:0]    empty_q, empty_d;
  logic                    err_q, err_d;

  // Combinational helpers
  logic                    slot_free_s;
  logic [num_lce_p-1:0]    elig_s;
  logic                    gnt_found_s;
  logic [id_width_lp-1:0]  gnt_id_s;
  logic [id_width_lp-1:0]  idx_s;
  logic [num_lce_p-1:0]    gnt_oh_s;
  logic [num_lce_p-1:0]    acc_s;
  logic                    acc_any_s;
  logic [req_width_p-1:0]  gnt_data_s;

  // The slot can take a beat when empty or when it drains this cycle.
  assign slot_free_s = ~v_q | lce_req_ready_i;
  assign elig_s      = lce_req_v_i & ~full_q;
  assign acc_s       = gnt_oh_s & lce_req_v_i;
  assign acc_any_s   = |acc_s;

  // Pick the winner: the locked channel only, or round-robin from last_gnt+1.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = last_gnt_q;
    idx_s       = last_gnt_q;
    if (locked_q) begin
      gnt_found_s = elig_s[last_gnt_q];
      gnt_id_s    = last_gnt_q;
    end else begin
      for (int k = 1; k <= num_lce_p; k++) begin
        idx_s = id_width_lp'((int'(last_gnt_q) + k) % num_lce_p);
        if (!gnt_found_s && elig_s[idx_s]) begin
          gnt_found_s = 1'b1;
          gnt_id_s    = idx_s;
        end else begin
          gnt_found_s = gnt_found_s;
        end
      end
    end
  end

  // One-hot ready; held low in reset so nothing is accepted before release.
  always_comb begin
    gnt_oh_s = {num_lce_p{1'b0}};
    if (gnt_found_s && slot_free_s && reset_n_i) begin
      gnt_oh_s[gnt_id_s] = 1'b1;
    end else begin
      gnt_oh_s = {num_lce_p{1'b0}};
    end
  end

  assign lce_req_ready_o = gnt_oh_s;

  // Mux the granted channel's packet.
  always_comb begin
    gnt_data_s = {req_width_p{1'b0}};
    for (int i = 0; i < num_lce_p; i++) begin
      if (gnt_oh_s[i]) begin
        gnt_data_s = lce_req_i[i*req_width_p +: req_width_p];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // Next state of the output slot, round-robin pointer and lock.
  always_comb begin
    v_d        = v_q;
    data_d     = data_q;
    src_d      = src_q;
    last_gnt_d = last_gnt_q;
    locked_d   = locked_q;
    if (slot_free_s) begin
      v_d = acc_any_s;
    end else begin
      v_d = v_q;
    end
    if (acc_any_s) begin
      data_d     = gnt_data_s;
      src_d      = gnt_id_s;
      last_gnt_d = gnt_id_s;
      locked_d   = (lock_en_p != 0) && lce_req_lock_i[gnt_id_s];
    end else begin
      data_d     = data_q;
      src_d      = src_q;
      last_gnt_d = last_gnt_q;
      locked_d   = locked_q;
    end
  end

  // Credit counters: accept adds, return subtracts, both together cancel;
  // a lone return on an empty counter is an underflow and sets the sticky error.
  always_comb begin
    err_d   = err_q;
    full_d  = {num_lce_p{1'b0}};
    empty_d = {num_lce_p{1'b0}};
    for (int i = 0; i < num_lce_p; i++) begin
      cnt_d[i] = cnt_q[i];
      if (acc_s[i] && credit_return_i[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (acc_s[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_one_lp;
      end else if (credit_return_i[i]) begin
        if (cnt_q[i] == cnt_zero_lp) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - cnt_one_lp;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      full_d[i]  = (cnt_d[i] == credits_lp);
      empty_d[i] = (cnt_d[i] == cnt_zero_lp);
    end
  end

  // State registers; reset drops the held beat and every credit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q        <= 1'b0;
      data_q     <= {req_width_p{1'b0}};
      src_q      <= {id_width_lp{1'b0}};
      last_gnt_q <= last_id_lp;
      locked_q   <= 1'b0;
      full_q     <= {num_lce_p{1'b0}};
      empty_q    <= {num_lce_p{1'b1}};
      err_q      <= 1'b0;
      for (int i = 0; i < num_lce_p; i++) begin
        cnt_q[i] <= cnt_zero_lp;
      end
    end else begin
      v_q        <= v_d;
      data_q     <= data_d;
      src_q      <= src_d;
      last_gnt_q <= last_gnt_d;
      locked_q   <= locked_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
      for (int i = 0; i < num_lce_p; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign lce_req_o       = data_q;
  assign lce_req_src_o   = src_q;
  assign lce_req_v_o     = v_q;
  assign credits_full_o  = full_q;
  assign credits_empty_o = empty_q;
  assign credit_err_o    = err_q;

endmodule

// File: tb/tb_bp_core_lce_req_arbiter.sv
// Directed bench for bp_core_lce_req_arbiter with 3 channels and 2 credits.
// Expected beats are queued when the bench predicts an accept and compared
// when the output slot presents them.
module tb_bp_core_lce_req_arbiter;
  localparam int N = 3;
  localparam int W = 16;
  localparam int C = 2;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N*W-1:0] lce_req_i;
  logic [N-1:0]   lce_req_v_i;
  logic [N-1:0]   lce_req_lock_i;
  logic [N-1:0]   lce_req_ready_o;
  logic [N-1:0]   credit_return_i;
  logic [N-1:0]   credits_full_o;
  logic [N-1:0]   credits_empty_o;
  logic [W-1:0]   lce_req_o;
  logic [1:0]     lce_req_src_o;
  logic           lce_req_v_o;
  logic           lce_req_ready_i;
  logic           credit_err_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit model_vo     = 1'b0;
  logic [17:0] exp_q[$];

  bp_core_lce_req_arbiter #(
    .num_lce_p(N), .req_width_p(W), .credits_p(C), .lock_en_p(1)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i),
    .lce_req_lock_i(lce_req_lock_i), .lce_req_ready_o(lce_req_ready_o),
    .credit_return_i(credit_return_i), .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o), .lce_req_o(lce_req_o),
    .lce_req_src_o(lce_req_src_o), .lce_req_v_o(lce_req_v_o),
    .lce_req_ready_i(lce_req_ready_i), .credit_err_o(credit_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int i, input int c);
    return {4'(i), 4'hC, 8'(c)};
  endfunction

  // One clock cycle: drive inputs, check slot contents and grant, predict.
  task automatic beat(input logic [2:0] v, input logic [2:0] lk, input logic [2:0] rt,
                      input logic rdy, input logic [2:0] exp_rdy, input string tag);
    lce_req_v_i     = v;
    lce_req_lock_i  = lk;
    credit_return_i = rt;
    lce_req_ready_i = rdy;
    for (int i = 0; i < N; i++) lce_req_i[i*W +: W] = chan_data(i, cyc);
    #1;
    check({tag, ":vo"}, 32'(lce_req_v_o), 32'(model_vo));
    if (lce_req_v_o) begin
      check({tag, ":sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check({tag, ":src"}, 32'(lce_req_src_o), 32'(exp_q[0][17:16]));
        check({tag, ":data"}, 32'(lce_req_o), 32'(exp_q[0][15:0]));
        if (rdy) void'(exp_q.pop_front());
      end
    end
    check({tag, ":ready"}, 32'(lce_req_ready_o), 32'(exp_rdy));
    for (int i = 0; i < N; i++)
      if (exp_rdy[i]) exp_q.push_back({2'(i), chan_data(i, cyc)});
    model_vo = (exp_rdy != 3'b000) || (model_vo && !rdy);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic status(input string tag, input logic [2:0] f, input logic [2:0] e, input logic er);
    check({tag, ":full"}, 32'(credits_full_o), 32'(f));
    check({tag, ":empty"}, 32'(credits_empty_o), 32'(e));
    check({tag, ":err"}, 32'(credit_err_o), 32'(er));
  endtask

  initial begin
    reset_n_i       = 1'b1;
    lce_req_i       = '0;
    lce_req_v_i     = 3'b111;
    lce_req_lock_i  = 3'b000;
    credit_return_i = 3'b000;
    lce_req_ready_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #1;
    check("rst:vo", 32'(lce_req_v_o), 32'd0);
    check("rst:data", 32'(lce_req_o), 32'd0);
    check("rst:src", 32'(lce_req_src_o), 32'd0);
    status("rst", 3'b000, 3'b111, 1'b0);
    check("rst:ready", 32'(lce_req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("rst:ready_held", 32'(lce_req_ready_o), 32'd0);
    reset_n_i = 1'b1;

    // Fairness: 0,1,2,0,1,2 then every channel is out of credits.
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b001, "fair0");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b010, "fair1");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b100, "fair2");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b001, "fair3");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b010, "fair4");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b100, "fair5");
    beat(3'b111, 3'b000, 3'b000, 1'b1, 3'b000, "allfull");
    status("allfull", 3'b111, 3'b000, 1'b0);
    beat(3'b000, 3'b000, 3'b111, 1'b1, 3'b000, "ret_a");
    beat(3'b000, 3'b000, 3'b111, 1'b1, 3'b000, "ret_b");
    status("ret", 3'b000, 3'b111, 1'b0);

    // Backpressure: one beat held for 5 cycles, then drain and refill.
    beat(3'b001, 3'b000, 3'b000, 1'b0, 3'b001, "bp_load");
    for (int k = 0; k < 5; k++) beat(3'b011, 3'b000, 3'b000, 1'b0, 3'b000, "bp_hold");
    beat(3'b011, 3'b000, 3'b000, 1'b1, 3'b010, "bp_refill");
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "bp_drain");
    beat(3'b000, 3'b000, 3'b011, 1'b1, 3'b000, "bp_ret");

    // Credits: channel 0 fills, channel 1 alone is granted until a return.
    beat(3'b001, 3'b000, 3'b000, 1'b1, 3'b001, "cr0");
    beat(3'b001, 3'b000, 3'b000, 1'b1, 3'b001, "cr1");
    beat(3'b011, 3'b000, 3'b000, 1'b1, 3'b010, "cr_full0");
    status("cr_full0", 3'b001, 3'b100, 1'b0);
    beat(3'b011, 3'b000, 3'b001, 1'b1, 3'b010, "cr_ret0");
    status("cr_ret0", 3'b010, 3'b100, 1'b0);
    beat(3'b011, 3'b000, 3'b000, 1'b1, 3'b001, "cr_regrant0");
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "cr_drain");
    beat(3'b000, 3'b000, 3'b011, 1'b1, 3'b000, "cr_clr_a");
    beat(3'b000, 3'b000, 3'b011, 1'b1, 3'b000, "cr_clr_b");
    status("cr_clr", 3'b000, 3'b111, 1'b0);

    // Simultaneous accept and return, then underflow.
    beat(3'b010, 3'b000, 3'b000, 1'b1, 3'b010, "sim0");
    beat(3'b010, 3'b000, 3'b010, 1'b1, 3'b010, "sim1");
    status("sim", 3'b000, 3'b101, 1'b0);
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "sim_drain");
    beat(3'b000, 3'b000, 3'b100, 1'b1, 3'b000, "uflow");
    status("uflow", 3'b000, 3'b101, 1'b1);
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "uflow_idle");
    status("uflow_sticky", 3'b000, 3'b101, 1'b1);
    beat(3'b000, 3'b000, 3'b010, 1'b1, 3'b000, "uflow_clr");
    status("uflow_clr", 3'b000, 3'b111, 1'b1);

    // Lock: channel 1 keeps the grant over channel 0 until a lock=0 beat.
    beat(3'b001, 3'b000, 3'b000, 1'b1, 3'b001, "lk_pre");
    beat(3'b011, 3'b010, 3'b000, 1'b1, 3'b010, "lk1");
    beat(3'b001, 3'b000, 3'b000, 1'b1, 3'b000, "lk_gap");
    beat(3'b011, 3'b010, 3'b010, 1'b1, 3'b010, "lk2");
    beat(3'b011, 3'b000, 3'b010, 1'b1, 3'b010, "lk3");
    beat(3'b011, 3'b000, 3'b000, 1'b1, 3'b001, "lk_rel");
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "lk_drain");
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with a held beat and nonzero counts.
    beat(3'b100, 3'b000, 3'b000, 1'b0, 3'b100, "rst_load");
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_mid:vo", 32'(lce_req_v_o), 32'd0);
    status("rst_mid", 3'b000, 3'b111, 1'b0);
    check("rst_mid:ready", 32'(lce_req_ready_o), 32'd0);
    exp_q.delete();
    model_vo = 1'b0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    beat(3'b000, 3'b000, 3'b000, 1'b1, 3'b000, "post_rst");
    status("post_rst", 3'b000, 3'b111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
